// File: rtl/sample_page_buffer_pkg.sv
// sample_page_buffer_pkg: read-side state encoding, default geometry
// and a clog2 helper shared by the page buffer and its register banks.
package sample_page_buffer_pkg;

   localparam int PAGE_BYTES_DEF   = 64;
   localparam int EEPROM_BYTES_DEF = 32768;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } rd_state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/sample_page_buffer_page_bank.sv
// page_bank: one DEPTH x 8 register bank.
// Ports: clk; we/waddr/wdata write port; raddr/rdata combinational read.
module page_bank
   import sample_page_buffer_pkg::*;
#(
   parameter int DEPTH = PAGE_BYTES_DEF,
   parameter int IDX_W = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  logic [7:0]       wdata,
   input  logic [IDX_W-1:0] raddr,
   output logic [7:0]       rdata
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sample_page_buffer.sv
// sample_page_buffer: ping-pong page assembler from ADC samples to
// an EEPROM writer byte stream.
// Ports: CLK_50MHz, RESET (async, active-low); Sample_word/sample_valid
// sample input; page_byte/page_valid/page_ready/page_last byte stream
// with page_addr; status mem_full, overflow, drop_count.
module sample_page_buffer
   import sample_page_buffer_pkg::*;
#(
   parameter int PAGE_BYTES   = PAGE_BYTES_DEF,
   parameter int EEPROM_BYTES = EEPROM_BYTES_DEF,
   parameter int ADDR_W       = 15,
   parameter bit WRAP         = 1'b0,
   parameter int DROP_W       = 16
) (
   input  logic              CLK_50MHz,
   input  logic              RESET,
   input  logic [7:0]        Sample_word,
   input  logic              sample_valid,
   output logic [7:0]        page_byte,
   output logic              page_valid,
   input  logic              page_ready,
   output logic              page_last,
   output logic [ADDR_W-1:0] page_addr,
   output logic              mem_full,
   output logic              overflow,
   output logic [DROP_W-1:0] drop_count
);

   localparam int IDX_W = clog2(PAGE_BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX =
      IDX_W'(PAGE_BYTES - 1);
   localparam logic [ADDR_W-1:0] LAST_PAGE =
      ADDR_W'(EEPROM_BYTES - PAGE_BYTES);
   localparam logic [ADDR_W-1:0] PAGE_STEP =
      ADDR_W'(PAGE_BYTES);

   rd_state_t        state;
   logic [1:0]       full;
   logic [1:0]       set_full;
   logic [1:0]       clr_full;
   logic             wr_bank;
   logic             rd_bank;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;
   logic [7:0]       rd_data0;
   logic [7:0]       rd_data1;
   logic             accept;
   logic             xfer;
   logic             page_done;

   // Acceptance looks only at registered flags: a bank freed this
   // cycle is not writable until the next one.
   assign accept    = sample_valid && !full[wr_bank] && !mem_full;
   assign xfer      = page_valid && page_ready;
   assign page_last = page_valid && (rd_idx == LAST_IDX);
   assign page_done = xfer && page_last;
   assign page_byte = page_valid
                    ? (rd_bank ? rd_data1 : rd_data0)
                    : 8'h00;

   assign set_full = (accept && (wr_idx == LAST_IDX))
                   ? (wr_bank ? 2'b10 : 2'b01)
                   : 2'b00;
   assign clr_full = page_done
                   ? (rd_bank ? 2'b10 : 2'b01)
                   : 2'b00;

   page_bank #(
      .DEPTH (PAGE_BYTES),
      .IDX_W (IDX_W)
   ) u_bank0 (
      .clk   (CLK_50MHz),
      .we    (accept && !wr_bank),
      .waddr (wr_idx),
      .wdata (Sample_word),
      .raddr (rd_idx),
      .rdata (rd_data0)
   );

   page_bank #(
      .DEPTH (PAGE_BYTES),
      .IDX_W (IDX_W)
   ) u_bank1 (
      .clk   (CLK_50MHz),
      .we    (accept && wr_bank),
      .waddr (wr_idx),
      .wdata (Sample_word),
      .raddr (rd_idx),
      .rdata (rd_data1)
   );

   always_ff @(posedge CLK_50MHz or negedge RESET) begin
      if (!RESET) begin
         full       <= 2'b00;
         wr_bank    <= 1'b0;
         wr_idx     <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         // Set and clear never hit the same bank: a set needs the
         // bank empty, a clear needs it full.
         full <= (full & ~clr_full) | set_full;
         if (accept) begin
            if (wr_idx == LAST_IDX) begin
               wr_idx  <= '0;
               wr_bank <= ~wr_bank;
            end else begin
               wr_idx <= wr_idx + IDX_W'(1);
            end
         end else if (sample_valid) begin
            overflow <= 1'b1;
            if (drop_count != '1)
               drop_count <= drop_count + DROP_W'(1);
         end
      end
   end

   always_ff @(posedge CLK_50MHz or negedge RESET) begin
      if (!RESET) begin
         state      <= IDLE;
         page_valid <= 1'b0;
         rd_bank    <= 1'b0;
         rd_idx     <= '0;
         page_addr  <= '0;
         mem_full   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (full[rd_bank] && !mem_full) begin
                  state      <= STREAM;
                  page_valid <= 1'b1;
               end
            end
            STREAM: begin
               if (xfer && !page_last) begin
                  rd_idx <= rd_idx + IDX_W'(1);
               end else if (xfer) begin
                  rd_idx     <= '0;
                  rd_bank    <= ~rd_bank;
                  page_valid <= 1'b0;
                  if (!WRAP && (page_addr == LAST_PAGE)) begin
                     mem_full <= 1'b1;
                     state    <= DONE;
                  end else begin
                     page_addr <= (page_addr == LAST_PAGE)
                                ? '0
                                : page_addr + PAGE_STEP;
                     state     <= IDLE;
                  end
               end
            end
            DONE: begin
               page_valid <= 1'b0;
            end
            default: begin
               state      <= IDLE;
               page_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sample_page_buffer.sv
// tb_sample_page_buffer: two buffers (WRAP=0 and WRAP=1, 4-page EEPROM)
// on shared stimulus, checked each cycle against a page-queue model.
module tb_sample_page_buffer;

   localparam int PB = 64;
   localparam int EB = 256;

   logic       CLK_50MHz;
   logic       RESET = 1'b1;
   logic [7:0] Sample_word = 8'h00;
   logic       sample_valid = 1'b0;
   logic       page_ready = 1'b0;

   logic [1:0]      pv;
   logic [1:0]      pl;
   logic [1:0]      mf;
   logic [1:0]      ov;
   logic [1:0][7:0] pb;
   logic [1:0][7:0] pa;
   logic [1:0][7:0] dc;

   int nchk = 0;
   int nerr = 0;

   // Model: completed pages wait in an in-order list of at most two.
   logic [7:0] m_pg  [2][2][PB];
   logic [7:0] m_cur [2][PB];
   int m_wc [2];
   int m_nq [2];
   int m_rdi[2];
   int m_adr[2];
   int m_dc [2];
   bit m_str[2];
   bit m_mf [2];
   bit m_ov [2];

   sample_page_buffer #(
      .PAGE_BYTES(PB), .EEPROM_BYTES(EB), .ADDR_W(8),
      .WRAP(1'b0), .DROP_W(8)
   ) u_nowrap (
      .CLK_50MHz(CLK_50MHz), .RESET(RESET),
      .Sample_word(Sample_word), .sample_valid(sample_valid),
      .page_byte(pb[0]), .page_valid(pv[0]),
      .page_ready(page_ready), .page_last(pl[0]),
      .page_addr(pa[0]), .mem_full(mf[0]),
      .overflow(ov[0]), .drop_count(dc[0])
   );

   sample_page_buffer #(
      .PAGE_BYTES(PB), .EEPROM_BYTES(EB), .ADDR_W(8),
      .WRAP(1'b1), .DROP_W(8)
   ) u_wrap (
      .CLK_50MHz(CLK_50MHz), .RESET(RESET),
      .Sample_word(Sample_word), .sample_valid(sample_valid),
      .page_byte(pb[1]), .page_valid(pv[1]),
      .page_ready(page_ready), .page_last(pl[1]),
      .page_addr(pa[1]), .mem_full(mf[1]),
      .overflow(ov[1]), .drop_count(dc[1])
   );

   initial begin
      CLK_50MHz = 1'b0;
      forever #5 CLK_50MHz = ~CLK_50MHz;
   end

   task automatic chk(input string nm, input int k,
                      input int act, input int exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s[dut%0d] t=%0t: got %0d, expected %0d",
                  nm, k, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_wc[k] = 0; m_nq[k] = 0; m_rdi[k] = 0;
         m_adr[k] = 0; m_dc[k] = 0;
         m_str[k] = 0; m_mf[k] = 0; m_ov[k] = 0;
      end
   endtask

   task automatic model_step(input bit sv, input logic [7:0] sw,
                             input bit rdy);
      for (int k = 0; k < 2; k++) begin
         bit xf, lst, acc, mf0;
         int nq0;
         xf  = m_str[k] && rdy;
         lst = (m_rdi[k] == PB - 1);
         acc = sv && (m_nq[k] < 2) && !m_mf[k];
         nq0 = m_nq[k];
         mf0 = m_mf[k];
         if (xf && lst) begin
            for (int j = 0; j < PB; j++) m_pg[k][0][j] = m_pg[k][1][j];
            m_nq[k]--;
            m_rdi[k] = 0;
            m_str[k] = 0;
            if (k == 0 && m_adr[k] == EB - PB) m_mf[k] = 1;
            else m_adr[k] = (m_adr[k] + PB) % EB;
         end else if (xf) begin
            m_rdi[k]++;
         end else if (!m_str[k] && nq0 > 0 && !mf0) begin
            m_str[k] = 1;
         end
         if (acc) begin
            m_cur[k][m_wc[k]] = sw;
            m_wc[k]++;
            if (m_wc[k] == PB) begin
               for (int j = 0; j < PB; j++)
                  m_pg[k][m_nq[k]][j] = m_cur[k][j];
               m_nq[k]++;
               m_wc[k] = 0;
            end
         end else if (sv) begin
            m_ov[k] = 1;
            if (m_dc[k] < 255) m_dc[k]++;
         end
      end
      if (!RESET) model_reset();
   endtask

   always @(negedge CLK_50MHz) begin
      for (int k = 0; k < 2; k++) begin
         chk("page_valid", k, int'(pv[k]), int'(m_str[k]));
         if (m_str[k])
            chk("page_byte", k, int'(pb[k]),
                int'(m_pg[k][0][m_rdi[k]]));
         chk("page_last", k, int'(pl[k]),
             int'(m_str[k] && m_rdi[k] == PB - 1));
         chk("page_addr", k, int'(pa[k]), m_adr[k]);
         chk("mem_full", k, int'(mf[k]), int'(m_mf[k]));
         chk("overflow", k, int'(ov[k]), int'(m_ov[k]));
         chk("drop_count", k, int'(dc[k]), m_dc[k]);
      end
   end

   task automatic cyc(input bit sv, input logic [7:0] sw,
                      input bit rdy);
      sample_valid = sv;
      Sample_word  = sw;
      page_ready   = rdy;
      @(posedge CLK_50MHz);
      model_step(sv, sw, rdy);
      #1;
   endtask

   task automatic do_reset();
      RESET = 1'b0;
      model_reset();
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_valid", k, int'(pv[k]), 0);
         chk("rst_byte", k, int'(pb[k]), 0);
         chk("rst_last", k, int'(pl[k]), 0);
         chk("rst_addr", k, int'(pa[k]), 0);
         chk("rst_full", k, int'(mf[k]), 0);
         chk("rst_ovf", k, int'(ov[k]), 0);
         chk("rst_drop", k, int'(dc[k]), 0);
      end
      cyc(0, 8'h00, 0);
      cyc(0, 8'h00, 0);
      RESET = 1'b1;
   endtask

   initial begin
      int nx;
      model_reset();
      #1;
      do_reset();

      // One page 0..63 with the writer always ready.
      for (int i = 0; i < PB; i++) cyc(1, 8'(i), 1);
      chk("pre_valid", 0, int'(pv[0]), 0);
      cyc(0, 8'h00, 1);
      chk("first_valid", 0, int'(pv[0]), 1);
      chk("first_byte", 0, int'(pb[0]), 0);
      chk("first_addr", 0, int'(pa[0]), 0);
      for (int j = 1; j < PB; j++) begin
         cyc(0, 8'h00, 1);
         chk("seq_byte", 0, int'(pb[0]), j);
         chk("seq_last", 0, int'(pl[0]), int'(j == PB - 1));
      end
      cyc(0, 8'h00, 1);
      chk("end_valid", 0, int'(pv[0]), 0);
      chk("end_addr", 0, int'(pa[0]), 64);
      chk("end_drop", 0, int'(dc[0]), 0);

      // Fill both banks with the writer stalled, then overrun.
      do_reset();
      for (int i = 0; i < 2 * PB; i++) cyc(1, 8'(i * 3 + 7), 0);
      chk("stall_valid", 0, int'(pv[0]), 1);
      chk("stall_byte", 0, int'(pb[0]), 7);
      cyc(1, 8'hEE, 0);
      chk("ovr_drop", 0, int'(dc[0]), 1);
      chk("ovr_flag", 0, int'(ov[0]), 1);
      chk("ovr_hold", 0, int'(pb[0]), 7);

      // Drain both pages in order.
      cyc(0, 8'h00, 1);
      chk("p0_byte1", 0, int'(pb[0]), 10);
      for (int j = 1; j < PB; j++) cyc(0, 8'h00, 1);
      chk("p0_end", 0, int'(pv[0]), 0);
      chk("p0_addr", 0, int'(pa[0]), 64);
      cyc(0, 8'h00, 1);
      chk("p1_valid", 0, int'(pv[0]), 1);
      chk("p1_byte0", 0, int'(pb[0]), 199);
      chk("p1_addr", 0, int'(pa[0]), 64);
      for (int j = 0; j < PB; j++) cyc(0, 8'h00, 1);
      chk("p1_addr_next", 0, int'(pa[0]), 128);

      // Third page with a randomly stalling writer.
      nx = 0;
      for (int i = 0; i < 214; i++) begin
         bit r;
         r = 1'($urandom_range(0, 1));
         if (pv[0] && r) nx++;
         cyc(i < PB, 8'(200 + i), r);
      end
      for (int i = 0; i < 70; i++) begin
         if (pv[0]) nx++;
         cyc(0, 8'h00, 1);
      end
      chk("rand_xfers", 0, nx, PB);
      chk("rand_addr", 0, int'(pa[0]), 192);

      // Fourth page fills the EEPROM on the non-wrapping buffer.
      for (int i = 0; i < PB; i++) cyc(1, 8'(255 - i), 1);
      cyc(0, 8'h00, 1);
      chk("p3_addr", 0, int'(pa[0]), 192);
      chk("p3_byte0", 0, int'(pb[0]), 255);
      for (int j = 0; j < PB; j++) cyc(0, 8'h00, 1);
      chk("full_set", 0, int'(mf[0]), 1);
      chk("full_addr", 0, int'(pa[0]), 192);
      chk("wrap_nofull", 1, int'(mf[1]), 0);
      chk("wrap_addr", 1, int'(pa[1]), 0);
      cyc(1, 8'h55, 1);
      chk("full_drop", 0, int'(dc[0]), 2);
      chk("wrap_drop", 1, int'(dc[1]), 1);
      for (int i = 1; i < PB; i++) cyc(1, 8'(8'h55 + i), 1);
      cyc(0, 8'h00, 1);
      chk("p4_valid", 1, int'(pv[1]), 1);
      chk("p4_addr", 1, int'(pa[1]), 0);
      chk("p4_byte0", 1, int'(pb[1]), 8'h55);
      chk("done_valid", 0, int'(pv[0]), 0);
      for (int j = 0; j < PB; j++) cyc(0, 8'h00, 1);
      chk("done_drop", 0, int'(dc[0]), 65);
      for (int i = 0; i < 300; i++) cyc(1, 8'(i), 1);
      chk("drop_sat", 0, int'(dc[0]), 255);

      // Reset in the middle of a stream.
      do_reset();
      for (int i = 0; i < PB; i++) cyc(1, 8'(i), 1);
      cyc(0, 8'h00, 1);
      for (int j = 1; j <= 30; j++) cyc(0, 8'h00, 1);
      chk("mid_byte", 0, int'(pb[0]), 30);
      do_reset();
      for (int i = 0; i < PB; i++) cyc(1, 8'(i + 1), 1);
      cyc(0, 8'h00, 1);
      chk("post_valid", 0, int'(pv[0]), 1);
      chk("post_addr", 0, int'(pa[0]), 0);
      chk("post_byte", 0, int'(pb[0]), 1);
      for (int j = 0; j < PB; j++) cyc(0, 8'h00, 1);
      chk("post_end", 0, int'(pa[0]), 64);

      $display("== %0d vectors applied, %0d miscompares ==",
               nchk, nerr);
      $finish;
   end

endmodule
